led_blink_drv: RTL and testbench
================================

// Module: led_blink_drv
// PURPOSE
//  Output-side counterpart of the button debouncer: converts a one-cycle request into N
//  millisecond-timed LED blinks on a board pin. Sits between control logic and an LED pad.
//  Provides busy/done handshake so software-visible logic can sequence requests.
// PARAMETERS
//  clk_freq   95000  clock frequency in kHz (clk cycles per 1 ms)
//  on_ms      100    LED on time per blink, ms (>=1)
//  off_ms     100    LED off time after each blink, ms (>=1)
//  cnt_w      4      width of blink_num / remaining-blink counter
// PORTS
//  clk        in   1      clock, all logic rising-edge
//  rst        in   1      asynchronous reset, active-low (rst==0 resets)
//  start      in   1      request pulse, sampled on rising clk
//  blink_num  in   cnt_w  blinks to emit, sampled with start
//  busy       out  1      high while a sequence is running
//  done       out  1      one-cycle pulse when a sequence completes
//  led_out    out  1      LED drive, registered, 1 = lit
//  abort      in   1      present only with LED_BLINK_ABORT_EN
// BEHAVIOUR
//  - Reset: state IDLE, led_out=0, busy=0, done=0, counters 0; reset mid-sequence drops LED at once.
//  - ms tick: prescaler counts 0..clk_freq-1, tick when ==clk_freq-1; cleared on accepted start.
//  - FSM IDLE/ON/OFF. IDLE: start=1 and blink_num!=0 -> latch rem=blink_num, go ON;
//    next cycle led_out=1, busy=1 (latency 1 clk).
//  - start with blink_num==0 in IDLE: no LED, busy stays 0, done=1 on next cycle.
//  - ON: led_out=1 for exactly on_ms*clk_freq cycles, then OFF, led_out=0.
//  - OFF: lasts exactly off_ms*clk_freq cycles; at end rem decrements; rem!=0 -> ON,
//    rem==0 -> IDLE, done=1 for one cycle, busy=0 same cycle.
//  - Total sequence = N*(on_ms+off_ms)*clk_freq cycles from first led_out=1 to done.
//  - start while busy=1 ignored (no queueing); start in the done cycle is accepted (IDLE).
//  - blink_num = 2^cnt_w-1 is legal; ms counter sized clog2(max(on_ms,off_ms)+1).
//  - Outputs glitch-free: all from flops, no combinational paths input->output.
// CONFIGURATION
//  LED_BLINK_ABORT_EN defined: abort port exists; abort=1 in ON/OFF -> IDLE next cycle,
//    led_out=0, busy=0, done NOT pulsed; abort ignored in IDLE; abort wins over start same cycle.
//  Undefined: no abort port; sequences always run to completion.
// STRUCTURE
//  - Shared package/header: FSM state encodings (IDLE=2'd0, ON=2'd1, OFF=2'd2),
//    ms-counter width function, LED polarity constant.
//  - One sub-module: ms_tick_gen (prescaler, clr input, one-cycle tick output, clk_freq param);
//    reusable by the debouncer family.
// TESTING (sim params clk_freq=4, on_ms=2, off_ms=3, cnt_w=4)
//  1 reset asserted mid-ON -> led_out,busy,done all 0 immediately; stay 0 after release.
//  2 start, blink_num=1 -> led_out=1 cycles 1..8, 0 cycles 9..20, done pulse cycle 20, busy low.
//  3 blink_num=3 -> exactly 3 high windows of 8 cycles, gaps 12 cycles, single done pulse.
//  4 start, blink_num=0 -> done next cycle, led_out never 1, busy never 1.
//  5 start re-pulsed while busy -> ignored; start on done cycle -> new sequence begins.
//  6 LED_BLINK_ABORT_EN: abort in 2nd ON of 3 -> led_out=0, busy=0 next cycle, no done.

Source files
------------

// File: rtl/led_blink_drv_pkg.sv
// Shared definitions for the LED blink driver: FSM encodings, ms-counter sizing, LED polarity.
// Latency: n/a (package only).  Backpressure: n/a.
package led_blink_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    localparam logic LED_ON  = 1'b1;
    localparam logic LED_OFF = ~LED_ON;

    function automatic int unsigned ms_cnt_width(input int unsigned on_ms, input int unsigned off_ms);
        int unsigned longest;
        longest = (on_ms > off_ms) ? on_ms : off_ms;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..clk_freq-1 and pulses tick_o on the last count; clr_i restarts it.
// Latency: tick_o decodes the counter register.  Backpressure: none, free-running.
module ms_tick_gen #(
    parameter int unsigned clk_freq = 95000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int unsigned W = (clk_freq > 1) ? $clog2(clk_freq) : 1;

    logic [W-1:0] cnt_q;

    // pre_tick_o flags the cycle before tick_o; it assumes clk_freq >= 2
    assign tick_o     = (cnt_q == W'(clk_freq - 1));
    assign pre_tick_o = (cnt_q == W'(clk_freq - 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/led_blink_drv.sv
// Turns a one-cycle start request into blink_num timed LED blinks with busy/done handshake.
// Latency: LED lights one clk after an accepted start.  Backpressure: start ignored while busy.
// Optional abort input enabled by defining LED_BLINK_ABORT_EN.
module led_blink_drv
    import led_blink_drv_pkg::*;
#(
    parameter int unsigned clk_freq = 95000,
    parameter int unsigned on_ms    = 100,
    parameter int unsigned off_ms   = 100,
    parameter int unsigned cnt_w    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [cnt_w-1:0] blink_num,
    output logic             busy,
    output logic             done,
    output logic             led_out
`ifdef LED_BLINK_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int unsigned MS_W = ms_cnt_width(on_ms, off_ms);

    state_e           state_q;
    logic [cnt_w-1:0] rem_q;
    logic [MS_W-1:0]  ms_q;
    logic             led_q;
    logic             busy_q;
    logic             done_q;

    logic tick;
    logic pre_tick;
    logic accept;
    logic abort_hit;
    logic on_end;
    logic off_end;
    logic off_last;

    assign accept = (state_q == ST_IDLE) && start && (blink_num != '0);

`ifdef LED_BLINK_ABORT_EN
    assign abort_hit = abort && (state_q != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    ms_tick_gen #(
        .clk_freq(clk_freq)
    ) u_ms_tick (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (accept),
        .tick_o    (tick),
        .pre_tick_o(pre_tick)
    );

    assign on_end  = tick && (ms_q == MS_W'(on_ms - 1));
    assign off_end = tick && (ms_q == MS_W'(off_ms - 1));
    // The done cycle doubles as the final off cycle, so the last OFF exits one clk early
    assign off_last = pre_tick && (ms_q == MS_W'(off_ms - 1)) && (rem_q == cnt_w'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            ms_q    <= '0;
            led_q   <= LED_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_hit) begin
                state_q <= ST_IDLE;
                rem_q   <= '0;
                ms_q    <= '0;
                led_q   <= LED_OFF;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            state_q <= ST_ON;
                            rem_q   <= blink_num;
                            ms_q    <= '0;
                            led_q   <= LED_ON;
                            busy_q  <= 1'b1;
                        end else if (start) begin
                            done_q <= 1'b1;
                        end
                    end
                    ST_ON: begin
                        if (on_end) begin
                            state_q <= ST_OFF;
                            ms_q    <= '0;
                            led_q   <= LED_OFF;
                        end else if (tick) begin
                            ms_q <= ms_q + MS_W'(1);
                        end
                    end
                    ST_OFF: begin
                        if (off_last) begin
                            state_q <= ST_IDLE;
                            rem_q   <= '0;
                            ms_q    <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (off_end) begin
                            state_q <= ST_ON;
                            rem_q   <= rem_q - cnt_w'(1);
                            ms_q    <= '0;
                            led_q   <= LED_ON;
                        end else if (tick) begin
                            ms_q <= ms_q + MS_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        rem_q   <= '0;
                        ms_q    <= '0;
                        led_q   <= LED_OFF;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign led_out = led_q;

endmodule

// File: tb/tb_led_blink_drv.sv
// Directed bench for led_blink_drv with clk_freq=4, on_ms=2, off_ms=3, cnt_w=4.
module tb_led_blink_drv;

    localparam int CF     = 4;
    localparam int ONM    = 2;
    localparam int OFFM   = 3;
    localparam int ON_CYC = ONM * CF;
    localparam int PER    = (ONM + OFFM) * CF;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] blink_num;
    logic       busy;
    logic       done;
    logic       led_out;
`ifdef LED_BLINK_ABORT_EN
    logic       abort;
`endif

    int total = 0;
    int bad   = 0;

    led_blink_drv #(
        .clk_freq(CF),
        .on_ms   (ONM),
        .off_ms  (OFFM),
        .cnt_w   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .blink_num(blink_num),
        .busy     (busy),
        .done     (done),
        .led_out  (led_out)
`ifdef LED_BLINK_ABORT_EN
        ,
        .abort    (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_led"}, {31'd0, led_out}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    // Called at cycle 1 of an n-blink sequence; checks cycles 1..last against the blink timeline.
    task automatic run_seq(input int id, input int n, input int last, input int repulse_at, input bit chain);
        for (int c = 1; c <= last; c++) begin
            chk($sformatf("t%0d_led_c%0d", id, c),  {31'd0, led_out}, {31'd0, (((c - 1) % PER) < ON_CYC)});
            chk($sformatf("t%0d_busy_c%0d", id, c), {31'd0, busy},    {31'd0, (c < n * PER)});
            chk($sformatf("t%0d_done_c%0d", id, c), {31'd0, done},    {31'd0, (c == n * PER)});
            if (c == repulse_at) begin
                start     = 1'b1;
                blink_num = 4'd5;
            end
            if (chain && c == n * PER) begin
                start     = 1'b1;
                blink_num = 4'd1;
            end
            step();
            start = 1'b0;
        end
    endtask

    task automatic kick(input logic [3:0] n);
        start     = 1'b1;
        blink_num = n;
        step();
        start     = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        blink_num = 4'd0;
`ifdef LED_BLINK_ABORT_EN
        abort     = 1'b0;
`endif
        #1;
        chk_quiet("reset");
        step();
        step();
        rst = 1'b1;
        step();
        chk_quiet("post_reset");

        // reset asserted in the middle of an ON window
        kick(4'd3);
        run_seq(1, 3, 2, 0, 1'b0);
        chk("t1_led_before_rst", {31'd0, led_out}, 32'd1);
        rst = 1'b0;
        #1;
        chk_quiet("t1_async");
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_quiet($sformatf("t1_after_c%0d", i));
        end

        // single blink
        kick(4'd1);
        run_seq(2, 1, PER, 0, 1'b0);
        chk_quiet("t2_idle");

        // three blinks
        kick(4'd3);
        run_seq(3, 3, 3 * PER, 0, 1'b0);
        chk_quiet("t3_idle");

        // zero blinks: immediate done, nothing else
        kick(4'd0);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_led",  {31'd0, led_out}, 32'd0);
        for (int i = 0; i < 25; i++) begin
            step();
            chk_quiet($sformatf("t4_after_c%0d", i));
        end

        // restart while busy ignored, start on the done cycle accepted
        kick(4'd2);
        run_seq(5, 2, 2 * PER, 7, 1'b1);
        run_seq(6, 1, PER, 13, 1'b0);
        chk_quiet("t6_idle");

        // maximum blink count
        kick(4'd15);
        run_seq(7, 15, 15 * PER, 0, 1'b0);
        chk_quiet("t7_idle");

`ifdef LED_BLINK_ABORT_EN
        // abort during the second ON window of three
        kick(4'd3);
        run_seq(8, 3, PER + 3, 0, 1'b0);
        chk("t8_led_before_abort", {31'd0, led_out}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_quiet("t8_abort");
        for (int i = 0; i < 45; i++) begin
            step();
            chk_quiet($sformatf("t8_after_c%0d", i));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
